// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose:
//   Shares one combinational ALU between two requesters. Each requester issues
//   an operation through a valid/ready handshake; when both are valid the
//   requester that did not win last time is granted. The granted opcode and
//   operands are registered and presented to the ALU for one cycle. The ALU
//   result is then captured and returned to the owning requester through its
//   own valid/ready response channel. Only one operation is in flight.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req0_*/req1_*             request channels: valid in, ready out, op/src1/src2
//   resp0_*/resp1_*           response channels: valid out, ready in
//   resp_res, resp_zero       captured result and zero flag, shared by both
//                             response channels
//   alu_op, alu_src1/2        registered drive to the external ALU
//   alu_res, alu_zero         result and zero flag from the external ALU
//   busy                      high whenever the FSM is not IDLE
//   owner                     requester owning the current or last operation
// -----------------------------------------------------------------------------
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module alu_arbiter #(
  parameter int ALU_OP_W = `ALU_OP_WIDTH,
  parameter int DATA_W   = `CPU_WIDTH
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic [DATA_W-1:0]   req0_src1,
  input  logic [DATA_W-1:0]   req0_src2,

  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ALU_OP_W-1:0] req1_op,
  input  logic [DATA_W-1:0]   req1_src1,
  input  logic [DATA_W-1:0]   req1_src2,

  output logic                resp0_valid,
  input  logic                resp0_ready,
  output logic                resp1_valid,
  input  logic                resp1_ready,
  output logic [DATA_W-1:0]   resp_res,
  output logic                resp_zero,

  output logic [ALU_OP_W-1:0] alu_op,
  output logic [DATA_W-1:0]   alu_src1,
  output logic [DATA_W-1:0]   alu_src2,
  input  logic [DATA_W-1:0]   alu_res,
  input  logic                alu_zero,

  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic                last_grant;
  logic                grant0;
  logic                grant1;
  logic                req0_fire;
  logic                req1_fire;
  logic                resp_fire;
  logic [ALU_OP_W-1:0] op_q;
  logic [DATA_W-1:0]   src1_q;
  logic [DATA_W-1:0]   src2_q;

  // Round-robin: a lone requester always wins; under contention the one that
  // was not granted last time wins. last_grant is only updated on a grant, so
  // a requester that drops valid without being served keeps its priority.
  assign grant0 = req0_valid & (~req1_valid | last_grant);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);

  assign req0_fire = req0_valid & req0_ready;
  assign req1_fire = req1_valid & req1_ready;
  assign resp_fire = owner ? (resp1_valid & resp1_ready)
                           : (resp0_valid & resp0_ready);

  // ALU inputs come straight from the captured registers in every state, so
  // they only move on the cycle after a request handshake.
  assign alu_op   = op_q;
  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req0_fire | req1_fire) state_next = EXEC;
      EXEC: state_next = RESP;
      RESP: if (resp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs
  // ---------------------------------------------------------------------------
  // Ready is gated by rst as well: the state is already IDLE during reset, but
  // no request may be accepted while reset is asserted.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    busy        = 1'b0;
    if (!rst) begin
      req0_ready  = (state == IDLE) & grant0;
      req1_ready  = (state == IDLE) & grant1;
      resp0_valid = (state == RESP) & ~owner;
      resp1_valid = (state == RESP) &  owner;
      busy        = (state != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture (request handshake) and result capture (end of EXEC)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      resp_res   <= '0;
      resp_zero  <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (req0_fire) begin
        op_q       <= req0_op;
        src1_q     <= req0_src1;
        src2_q     <= req0_src2;
        owner      <= 1'b0;
        last_grant <= 1'b0;
      end else if (req1_fire) begin
        op_q       <= req1_op;
        src1_q     <= req1_src1;
        src2_q     <= req1_src2;
        owner      <= 1'b1;
        last_grant <= 1'b1;
      end
      // Result is frozen from here until the next EXEC, which keeps it stable
      // for the whole RESP phase regardless of response backpressure.
      if (state == EXEC) begin
        resp_res  <= alu_res;
        resp_zero <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed testbench for alu_arbiter. Provides a small combinational ALU,
// drives directed request sequences, and checks responses against a queue of
// hand-computed expected results popped by a separate monitor thread.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int OPW = 4;
  localparam int DW  = 32;

  localparam logic [OPW-1:0] OP_ADD  = 4'd0;
  localparam logic [OPW-1:0] OP_SUB  = 4'd1;
  localparam logic [OPW-1:0] OP_AND  = 4'd2;
  localparam logic [OPW-1:0] OP_OR   = 4'd3;
  localparam logic [OPW-1:0] OP_XOR  = 4'd4;
  localparam logic [OPW-1:0] OP_SLL  = 4'd5;
  localparam logic [OPW-1:0] OP_SRL  = 4'd6;
  localparam logic [OPW-1:0] OP_SRA  = 4'd7;
  localparam logic [OPW-1:0] OP_SLT  = 4'd8;
  localparam logic [OPW-1:0] OP_SLTU = 4'd9;
  localparam logic [OPW-1:0] OP_BAD  = 4'd15;

  logic           clk;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [OPW-1:0] req0_op, req1_op;
  logic [DW-1:0]  req0_src1, req0_src2, req1_src1, req1_src2;
  logic           resp0_valid, resp1_valid;
  logic           resp0_ready, resp1_ready;
  logic [DW-1:0]  resp_res;
  logic           resp_zero;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_src1, alu_src2;
  logic [DW-1:0]  alu_res;
  logic           alu_zero;
  logic           busy;
  logic           owner;

  typedef struct {
    logic          ch;
    logic [DW-1:0] res;
    logic          zero;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  alu_arbiter #(.ALU_OP_W(OPW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_src1   (req0_src1),
    .req0_src2   (req0_src2),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_src1   (req1_src1),
    .req1_src2   (req1_src2),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_res    (resp_res),
    .resp_zero   (resp_zero),
    .alu_op      (alu_op),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .alu_res     (alu_res),
    .alu_zero    (alu_zero),
    .busy        (busy),
    .owner       (owner)
  );

  // Stand-in for the shared combinational ALU. Undefined opcodes give 0 with
  // zero=0.
  function automatic logic [DW:0] alu_f(logic [OPW-1:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          ok;
    r  = '0;
    ok = 1'b1;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'd0, a < b};
      default: ok = 1'b0;
    endcase
    return {ok & (r == '0), r};
  endfunction

  logic [DW:0] alu_out;
  assign alu_out  = alu_f(alu_op, alu_src1, alu_src2);
  assign alu_res  = alu_out[DW-1:0];
  assign alu_zero = alu_out[DW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor: whenever a response handshake is about to complete,
  // pop the oldest expected response and compare channel, result and flag.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("one_req_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        chk("one_resp_valid", {31'd0, resp0_valid & resp1_valid}, 32'd0);
        if ((resp0_valid & resp0_ready) | (resp1_valid & resp1_ready)) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: actual ch=%0d res=%0h required none", resp1_valid, resp_res);
          end else begin
            e = sb_q.pop_front();
            chk("resp_channel", {31'd0, resp1_valid}, {31'd0, e.ch});
            chk("resp_res", resp_res, e.res);
            chk("resp_zero", {31'd0, resp_zero}, {31'd0, e.zero});
          end
        end
      end
    end
  endtask

  task automatic expect_resp(input logic ch, input logic [DW-1:0] res, input logic zero);
    exp_t e;
    e.ch   = ch;
    e.res  = res;
    e.zero = zero;
    sb_q.push_back(e);
  endtask

  // Issues one operation with both response channels ready and waits
  // (bounded) for the grant, then for the FSM to return to IDLE.
  task automatic do_op(input logic ch, input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic got;
    got = 1'b0;
    if (ch) begin
      req1_valid = 1'b1; req1_op = op; req1_src1 = a; req1_src2 = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_src1 = a; req0_src2 = b;
    end
    for (int k = 0; k < 8; k++) begin
      #1;
      if (ch ? req1_ready : req0_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("op_granted", {31'd0, got}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    #1;
    chk("op_back_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_src1 = 32'd3; req0_src2 = 32'd4;
    req1_valid = 1'b0; req1_op = '0; req1_src1 = '0; req1_src2 = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("rst_alu_src1", alu_src1, 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Single ADD 5+7
    req0_valid = 1'b1; req0_op = OP_ADD; req0_src1 = 32'd5; req0_src2 = 32'd7;
    expect_resp(1'b0, 32'd12, 1'b0);
    #1;
    chk("add_req0_ready_T", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("add_alu_src1_T1", alu_src1, 32'd5);
    chk("add_alu_src2_T1", alu_src2, 32'd7);
    chk("add_busy_T1", {31'd0, busy}, 32'd1);
    chk("add_resp0_valid_T1", {31'd0, resp0_valid}, 32'd0);
    tick();
    #1;
    chk("add_resp0_valid_T2", {31'd0, resp0_valid}, 32'd1);
    chk("add_resp_res_T2", resp_res, 32'd12);
    tick();
    #1;
    chk("add_idle_T3", {31'd0, busy}, 32'd0);

    // Reset pulsed mid-EXEC: operation dropped, everything back to zero
    req0_valid = 1'b1; req0_op = OP_ADD; req0_src1 = 32'd1; req0_src2 = 32'd2;
    #1;
    chk("drop_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("drop_busy_exec", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("midrst_alu_src1", alu_src1, 32'd0);
    chk("midrst_alu_src2", alu_src2, 32'd0);
    chk("midrst_resp_res", resp_res, 32'd0);
    chk("midrst_resp_zero", {31'd0, resp_zero}, 32'd0);
    chk("midrst_owner", {31'd0, owner}, 32'd0);
    chk("midrst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("midrst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dropped_no_resp", {31'd0, resp0_valid}, 32'd0);
      tick();
    end

    // Contention: alternate 0,1,0,1 with grants every third cycle
    req0_valid = 1'b1; req0_op = OP_ADD; req0_src1 = 32'd1; req0_src2 = 32'd1;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_src1 = 32'd6; req1_src2 = 32'd3;
    expect_resp(1'b0, 32'd2, 1'b0);
    expect_resp(1'b1, 32'd5, 1'b0);
    expect_resp(1'b0, 32'd2, 1'b0);
    expect_resp(1'b1, 32'd5, 1'b0);
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("cont_req0_ready_c%0d", c), {31'd0, req0_ready},
          {31'd0, (c % 3 == 0) && ((c / 3) % 2 == 0)});
      chk($sformatf("cont_req1_ready_c%0d", c), {31'd0, req1_ready},
          {31'd0, (c % 3 == 0) && ((c / 3) % 2 == 1)});
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("cont_idle", {31'd0, busy}, 32'd0);

    // Backpressure on resp1 while req0 waits
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_src1 = 32'd9; req1_src2 = 32'd9;
    expect_resp(1'b1, 32'd0, 1'b1);
    #1;
    chk("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_src1 = 32'd1; req0_src2 = 32'd2;
    #1;
    chk("bp_req0_ready_exec", {31'd0, req0_ready}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_resp1_valid", {31'd0, resp1_valid}, 32'd1);
      chk("bp_resp_res", resp_res, 32'd0);
      chk("bp_resp_zero", {31'd0, resp_zero}, 32'd1);
      chk("bp_req0_ready", {31'd0, req0_ready}, 32'd0);
      chk("bp_resp0_valid", {31'd0, resp0_valid}, 32'd0);
      tick();
    end
    resp1_ready = 1'b1;
    expect_resp(1'b0, 32'd3, 1'b0);
    #1;
    chk("bp_release_valid", {31'd0, resp1_valid}, 32'd1);
    tick();
    #1;
    chk("bp_idle_after_ready", {31'd0, busy}, 32'd0);
    chk("bp_req0_granted", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();

    // Wrong-channel ready: owner 0, only resp1_ready high
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wc_resp0_valid", {31'd0, resp0_valid}, 32'd1);
      chk("wc_resp1_valid", {31'd0, resp1_valid}, 32'd0);
      chk("wc_busy", {31'd0, busy}, 32'd1);
      chk("wc_owner", {31'd0, owner}, 32'd0);
      tick();
    end
    resp0_ready = 1'b1;
    tick();
    #1;
    chk("wc_idle", {31'd0, busy}, 32'd0);

    // Wrap-around, unsigned compare, arithmetic shift, undefined opcode
    expect_resp(1'b0, 32'd0, 1'b1);
    do_op(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd1);
    expect_resp(1'b0, 32'd1, 1'b0);
    do_op(1'b0, OP_SLTU, 32'd3, 32'd4);
    expect_resp(1'b1, 32'hF800_0000, 1'b0);
    do_op(1'b1, OP_SRA, 32'h8000_0000, 32'd4);
    expect_resp(1'b1, 32'd0, 1'b0);
    do_op(1'b1, OP_BAD, 32'd5, 32'd5);

    tick();
    tick();
    chk("sb_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters, such as the execute stage and a future address/CSR helper path. Each request is accepted through a valid/ready handshake with round-robin priority. The granted operands are registered and presented to the ALU for one cycle. The result is captured and returned to the owning requester through its own valid/ready response channel. Exactly one operation is in flight at a time.

## Interface
- `ALU_OP_W`, default `` `ALU_OP_WIDTH ``: width of the ALU opcode.
- `DATA_W`, default `` `CPU_WIDTH ``: operand and result width.

- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid`, in, 1 each: request present.
- `req0_ready`, `req1_ready`, out, 1 each: request accepted this cycle.
- `req0_op`, `req1_op`, in, `ALU_OP_W` each: opcode, `` `ALU_ADD `` … `` `ALU_SLTU ``.
- `req0_src1`, `req0_src2`, `req1_src1`, `req1_src2`, in, `DATA_W` each: operands.
- `resp0_valid`, `resp1_valid`, out, 1 each: result available for that requester.
- `resp0_ready`, `resp1_ready`, in, 1 each: requester takes the result.
- `resp_res`, out, `DATA_W`: captured result, shared by both response channels.
- `resp_zero`, out, 1: captured zero flag.
- `alu_op`, out, `ALU_OP_W`: drives the ALU opcode input.
- `alu_src1`, `alu_src2`, out, `DATA_W` each: drive the ALU operand inputs.
- `alu_res`, in, `DATA_W`: result returned from the ALU.
- `alu_zero`, in, 1: zero flag returned from the ALU.
- `busy`, out, 1: state is not IDLE.
- `owner`, out, 1: index of the requester that owns the current or last operation.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE:**
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the requester that is not `last_grant`.
  - `reqN_ready` is `(state==IDLE) & grant_N`, combinational from `reqN_valid` and `last_grant`.
  - Only one ready is ever high.
  - On handshake: capture op and srcs into `op_q`, `src1_q` and `src2_q`; set `owner` and `last_grant` to N; go to EXEC.
- **EXEC:**
  - `alu_op`, `alu_src1` and `alu_src2` equal the captured registers. These outputs are driven from registers in every state.
  - At the end of the cycle, `alu_res` and `alu_zero` are captured into `resp_res` and `resp_zero`.
  - Next state is RESP.
- **RESP:**
  - `resp<owner>_valid` is 1 and the other response valid is 0.
  - `resp_res` and `resp_zero` hold stable until the response handshake.
  - On `resp<owner>_valid & resp<owner>_ready`, go to IDLE. Ready on the non-owner channel is ignored.
  - No new request is accepted in RESP.
- Undefined opcodes are passed to the ALU unchanged. The result is whatever the ALU returns (0, with zero=0).
- Requesters must hold valid, op and srcs stable until ready. The arbiter does not check this.
- Reset, including mid-operation:
  - State goes to IDLE. Any in-flight operation is dropped with no response.
  - `op_q`, `src1_q`, `src2_q`, `resp_res`, `resp_zero` and `owner` reset to 0.
  - `last_grant` resets to 1, so req0 wins the first contention.
  - All ready and valid outputs and `busy` are 0 while `rst` is high.

## Timing
- Request handshake at cycle T: EXEC in T+1, `respN_valid` high from T+2.
- Response handshake at cycle R: state is IDLE in R+1, and a new grant is possible in R+1.
- Peak throughput is one operation per 3 cycles.
- Two back-to-back contending requesters alternate strictly: 0, 1, 0, 1 …
- A requester that deasserts valid while not granted loses nothing. Priority is held only by `last_grant`.
- `busy` is high from T+1 through R, inclusive.
- The ALU inputs change only on the cycle after a request handshake.

## Test plan
- **Reset values:** `rst` pulsed mid-EXEC with req0 active → the same cycle shows all outputs 0 and `busy`=0, and no `resp0_valid` ever appears for the dropped operation.
- **Single ADD:** req0 with `` `ALU_ADD ``, 5 and 7, `resp0_ready`=1 → `req0_ready` at T, `alu_src1`=5 and `alu_src2`=7 at T+1, `resp0_valid` with `resp_res`=12 and `resp_zero`=0 at T+2, IDLE at T+3.
- **Contention:** req0 and req1 both valid continuously after reset → grant order 0, 1, 0, 1, with handshakes at cycles 0, 3, 6, 9 relative to the first.
- **Backpressure:** req1 with `` `ALU_SUB ``, 9 and 9, `resp1_ready` held 0 for 4 cycles → `resp1_valid` stays high with `resp_res`=0 and `resp_zero`=1 stable, `req0_ready` stays 0 throughout, and IDLE follows the cycle after ready rises.
- **Wrong-channel ready:** owner=0 in RESP, `resp1_ready`=1 and `resp0_ready`=0 → no transition, and `resp1_valid` stays 0.
- **Wrap-around:** `` `ALU_ADD `` with 0xFFFFFFFF and 1 → `resp_res`=0 and `resp_zero`=1. Then `` `ALU_SLTU `` with 3 and 4 → `resp_res`=1.
